// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the shift operand stage
package shift_pkg;

    localparam int SH_N    = 32;
    localparam int SHAMT_W = $clog2(SH_N);

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRX = 3'b101;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_SLL  = 2'd1,
        SH_SRL  = 2'd2,
        SH_SRA  = 2'd3
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [SH_N-1:0]    sh_in;
        logic [SHAMT_W-1:0] sh_amt;
        shift_op_t          sh_op;
        logic               illegal;
    } shift_req_t;

endpackage

// File: rtl/shift_decode.sv
// rtl/shift_decode.sv - combinational shift op decode and shift amount select
module shift_decode
    import shift_pkg::*;
(
    input  logic [SH_N-1:0]    rs1,
    input  logic [SHAMT_W-1:0] rs2_low,
    input  logic [SHAMT_W-1:0] imm_shamt,
    input  logic               use_imm,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    output shift_req_t         req
);

    always_comb begin
        req.sh_in   = rs1;
        req.sh_amt  = use_imm ? imm_shamt : rs2_low;
        req.sh_op   = SH_NONE;
        req.illegal = 1'b0;
        if (funct3 == FUNCT3_SLL) begin
            req.sh_op = SH_SLL;
        end else if (funct3 == FUNCT3_SRX) begin
            req.sh_op = funct7b5 ? SH_SRA : SH_SRL;
        end else begin
            // Non-shift ops still flow through so ordering is preserved downstream.
            req.illegal = 1'b1;
            req.sh_amt  = '0;
        end
    end

endmodule

// File: rtl/shift_operand_stage.sv
// rtl/shift_operand_stage.sv - two-entry skid-buffered issue stage feeding the shifters
module shift_operand_stage
    import shift_pkg::*;
#(
    parameter int N = SH_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         rs1,
    input  logic [N-1:0]         rs2,
    input  logic [$clog2(N)-1:0] imm_shamt,
    input  logic                 use_imm,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         sh_in,
    output logic [$clog2(N)-1:0] sh_amt,
    output logic [1:0]           sh_op,
    output logic                 illegal,
    output logic [15:0]          issued_count
);

    stage_state_t state_q, state_d;
    shift_req_t   main_q, skid_q, dec_req;
    logic         in_ready_q;
    logic [15:0]  count_q;
    logic         accept, issue;
    logic         load_main, load_skid, pop_skid;
    logic         unused_rs2_high;

    assign unused_rs2_high = ^rs2[N-1:$clog2(N)];

    shift_decode u_decode (
        .rs1       (rs1),
        .rs2_low   (rs2[$clog2(N)-1:0]),
        .imm_shamt (imm_shamt),
        .use_imm   (use_imm),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .req       (dec_req)
    );

    assign in_ready  = in_ready_q & ~rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && issue) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = ST_TWO;
                end else if (issue) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (issue) begin
                    pop_skid = 1'b1;
                    state_d  = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_main) begin
                main_q <= dec_req;
            end else if (pop_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_req;
            end
            if (issue) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign sh_in        = main_q.sh_in;
    assign sh_amt       = main_q.sh_amt;
    assign sh_op        = main_q.sh_op;
    assign illegal      = main_q.illegal;
    assign issued_count = count_q;

endmodule

// File: tb/tb_shift_operand_stage.sv
// tb/tb_shift_operand_stage.sv - directed self-checking bench for shift_operand_stage
module tb_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  imm_shamt;
    logic        use_imm;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sh_in;
    logic [4:0]  sh_amt;
    logic [1:0]  sh_op;
    logic        illegal;
    logic [15:0] issued_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_operand_stage #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .imm_shamt    (imm_shamt),
        .use_imm      (use_imm),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sh_in        (sh_in),
        .sh_amt       (sh_amt),
        .sh_op        (sh_op),
        .illegal      (illegal),
        .issued_count (issued_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] imm,
                          input logic ui, input logic [2:0] f3, input logic f7);
        rs1 = a; rs2 = b; imm_shamt = imm; use_imm = ui; funct3 = f3; funct7b5 = f7;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 3'b000, 1'b0);

        // reset state
        tick(); tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_sh_in",     sh_in,              32'd0);
        check("rst_sh_op",     {30'b0, sh_op},     32'd0);
        check("rst_count",     {16'b0, issued_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // 1: SRA with immediate
        set_op(32'h8000_0000, 32'h0, 5'd4, 1'b1, 3'b101, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check("t1_sh_in",     sh_in,              32'h8000_0000);
        check("t1_sh_amt",    {27'b0, sh_amt},    32'd4);
        check("t1_sh_op",     {30'b0, sh_op},     32'd3);
        check("t1_illegal",   {31'b0, illegal},   32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_count",     {16'b0, issued_count}, 32'd1);
        check("t1_drained",   {31'b0, out_valid}, 32'd0);

        // 2: register shamt masked to low 5 bits
        set_op(32'h0000_1234, 32'h0000_0125, 5'd31, 1'b0, 3'b001, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t2_sh_amt", {27'b0, sh_amt}, 32'd5);
        check("t2_sh_op",  {30'b0, sh_op},  32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 3: backpressure, clear counter first
        rst = 1'b1; tick(); rst = 1'b0;
        set_op(32'hAAAA_0001, 32'h0, 5'd1, 1'b1, 3'b001, 1'b0);
        in_valid = 1'b1;
        tick();
        check("t3_ready_after_a", {31'b0, in_ready}, 32'd1);
        set_op(32'hBBBB_0002, 32'h0, 5'd2, 1'b1, 3'b101, 1'b0);
        tick();
        check("t3_ready_after_b", {31'b0, in_ready}, 32'd0);
        set_op(32'hCCCC_0003, 32'h0, 5'd3, 1'b1, 3'b101, 1'b1);
        tick();
        check("t3_stall_sh_in",  sh_in,           32'hAAAA_0001);
        check("t3_stall_sh_amt", {27'b0, sh_amt}, 32'd1);
        tick();
        check("t3_stall2_sh_in", sh_in,           32'hAAAA_0001);
        check("t3_stall2_op",    {30'b0, sh_op},  32'd1);
        check("t3_stall_ready",  {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("t3_b_sh_in",  sh_in,              32'hBBBB_0002);
        check("t3_b_op",     {30'b0, sh_op},     32'd2);
        check("t3_count1",   {16'b0, issued_count}, 32'd1);
        check("t3_ready_up", {31'b0, in_ready},  32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_c_sh_in", sh_in,                32'hCCCC_0003);
        check("t3_c_op",    {30'b0, sh_op},       32'd3);
        check("t3_count2",  {16'b0, issued_count}, 32'd2);
        tick();
        check("t3_count3",  {16'b0, issued_count}, 32'd3);
        check("t3_empty",   {31'b0, out_valid},   32'd0);

        // 4: streaming 20 ops back-to-back
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_op(32'd100 + 32'(i), 32'h0, 5'(i), 1'b1, 3'b001, 1'b0);
            tick();
            check("t4_in_ready",  {31'b0, in_ready},  32'd1);
            check("t4_out_valid", {31'b0, out_valid}, 32'd1);
            check("t4_sh_in",     sh_in,              32'd100 + 32'(i));
            check("t4_count",     {16'b0, issued_count}, 32'd3 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("t4_final_count", {16'b0, issued_count}, 32'd23);
        out_ready = 1'b0;

        // 5: illegal op and SRL decode
        set_op(32'hDEAD_BEEF, 32'h0, 5'd7, 1'b1, 3'b000, 1'b0);
        in_valid = 1'b1;
        tick();
        set_op(32'h0000_00F0, 32'h0000_0003, 5'd9, 1'b0, 3'b101, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t5_ill_op",      {30'b0, sh_op},   32'd0);
        check("t5_ill_flag",    {31'b0, illegal}, 32'd1);
        check("t5_ill_amt",     {27'b0, sh_amt},  32'd0);
        check("t5_ill_sh_in",   sh_in,            32'hDEAD_BEEF);
        out_ready = 1'b1;
        tick();
        check("t5_srl_op",      {30'b0, sh_op},   32'd2);
        check("t5_srl_amt",     {27'b0, sh_amt},  32'd3);
        check("t5_srl_illegal", {31'b0, illegal}, 32'd0);
        check("t5_count",       {16'b0, issued_count}, 32'd24);
        tick();
        out_ready = 1'b0;

        // 6: reset while holding two entries
        in_valid = 1'b1;
        set_op(32'h1111_1111, 32'h0, 5'd1, 1'b1, 3'b001, 1'b0);
        tick();
        set_op(32'h2222_2222, 32'h0, 5'd2, 1'b1, 3'b001, 1'b0);
        tick();
        check("t6_full", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        check("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("t6_rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("t6_rst_count",     {16'b0, issued_count}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t6_in_ready_after", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("t6_no_stale_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("t6_no_stale_count", {16'b0, issued_count}, 32'd0);

        // counter wrap: 65535 issues to reach 0xFFFF, then one more
        in_valid = 1'b1;
        set_op(32'h5, 32'h0, 5'd1, 1'b1, 3'b001, 1'b0);
        tick();
        for (int i = 0; i < 65535; i++) tick();
        check("wrap_ffff", {16'b0, issued_count}, 32'h0000_FFFF);
        in_valid = 1'b0;
        tick();
        check("wrap_zero", {16'b0, issued_count}, 32'h0000_0000);
        check("wrap_empty", {31'b0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
